// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the iterative encryption controller:
//   - FSM state type for the controller
//   - round count, block width and last-round index constants
//   - S-box table plus SubBytes / ShiftRows / MixColumns / SubWord helpers
//   - round-constant lookup
// Byte order everywhere is FIPS-197: bit 127 is byte 0, and byte i sits at
// row i%4, column i/4 of the 4x4 state.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_ROUNDS  = 10;
    localparam int AES_BLOCK_W = 128;

    localparam logic [3:0] AES_LAST_ROUND = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } aes_state_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - (8 * int'(b));
        return SBOX_TABLE[idx -: 8];
    endfunction

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = 128'd0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
        end
        return r;
    endfunction

    // Row r of the output, column c, comes from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127 - 8*(rw + 4*c) -: 8] = s[127 - 8*(rw + 4*((c + rw) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            r[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// -----------------------------------------------------------------------------
// aes_key_step
// One combinational AES-128 key-schedule step: derives the next round key
// from the current one and the round constant.
// Ports:
//   rk      [127:0] in   current round key (w0 in bits 127:96)
//   rcon    [7:0]   in   round constant for the round being produced
//   rk_next [127:0] out  next round key
// -----------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] rk,
    input  logic [7:0]             rcon,
    output logic [AES_BLOCK_W-1:0] rk_next
);

    logic [31:0] w0_s;
    logic [31:0] w1_s;
    logic [31:0] w2_s;
    logic [31:0] w3_s;
    logic [31:0] temp_s;
    logic [31:0] n0_s;
    logic [31:0] n1_s;
    logic [31:0] n2_s;
    logic [31:0] n3_s;

    assign w0_s = rk[127:96];
    assign w1_s = rk[95:64];
    assign w2_s = rk[63:32];
    assign w3_s = rk[31:0];

    // RotWord is a one-byte left rotation; rcon lands in the leading byte.
    assign temp_s = sub_word({w3_s[23:0], w3_s[31:24]}) ^ {rcon, 24'h000000};

    assign n0_s = w0_s ^ temp_s;
    assign n1_s = w1_s ^ n0_s;
    assign n2_s = w2_s ^ n1_s;
    assign n3_s = w3_s ^ n2_s;

    assign rk_next = {n0_s, n1_s, n2_s, n3_s};

endmodule

// File: rtl/aes_iter_ctrl.sv
// -----------------------------------------------------------------------------
// aes_iter_ctrl
// Iterative AES-128 encryption engine: one round per clock, one block in
// flight at a time (IDLE -> RUN x10 -> DONE -> IDLE).
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   plaintext/key pair offered
//   in_ready   out  pair can be accepted (IDLE only)
//   in_key     in   128-bit cipher key, FIPS-197 byte order
//   in_text    in   128-bit plaintext, FIPS-197 byte order
//   out_valid  out  ciphertext available (DONE only)
//   out_ready  in   consumer takes the ciphertext
//   out_text   out  ciphertext (the state register)
//   busy       out  high in RUN or DONE
//   round_idx  out  0 in IDLE, 1..10 in RUN, 10 in DONE
// -----------------------------------------------------------------------------
module aes_iter_ctrl
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_key,
    input  logic [AES_BLOCK_W-1:0] in_text,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_text,
    output logic                   busy,
    output logic [3:0]             round_idx
);

    aes_state_e             fsm_q;
    aes_state_e             fsm_d;
    logic [AES_BLOCK_W-1:0] state_q;
    logic [AES_BLOCK_W-1:0] state_d;
    logic [AES_BLOCK_W-1:0] rk_q;
    logic [AES_BLOCK_W-1:0] rk_d;
    logic [3:0]             round_q;
    logic [3:0]             round_d;

    logic [7:0]             rcon_s;
    logic [AES_BLOCK_W-1:0] rk_next_s;
    logic [AES_BLOCK_W-1:0] shifted_s;
    logic [AES_BLOCK_W-1:0] mixed_s;
    logic [AES_BLOCK_W-1:0] round_out_s;
    logic                   last_round_s;

    assign rcon_s = rcon_of(round_q);

    aes_key_step u_key_step (
        .rk      (rk_q),
        .rcon    (rcon_s),
        .rk_next (rk_next_s)
    );

    // The round key used by a round is the one produced in that same round,
    // so the key step and the round transform run side by side.
    assign shifted_s    = shift_rows(sub_bytes(state_q));
    assign mixed_s      = mix_columns(shifted_s);
    assign last_round_s = (round_q == AES_LAST_ROUND);

    // Round result: the final round skips MixColumns.
    always_comb begin
        if (last_round_s) begin
            round_out_s = shifted_s ^ rk_next_s;
        end else begin
            round_out_s = mixed_s ^ rk_next_s;
        end
    end

    // Next-state and datapath-load decisions for the controller.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_text ^ in_key;
                    rk_d    = in_key;
                    round_d = 4'd1;
                    fsm_d   = ST_RUN;
                end else begin
                    fsm_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                state_d = round_out_s;
                rk_d    = rk_next_s;
                if (last_round_s) begin
                    fsm_d   = ST_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d   = ST_IDLE;
                    round_d = 4'd0;
                end else begin
                    fsm_d   = ST_DONE;
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                state_d = {AES_BLOCK_W{1'b0}};
                rk_d    = {AES_BLOCK_W{1'b0}};
                round_d = 4'd0;
            end
        endcase
    end

    // State, key and round registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= {AES_BLOCK_W{1'b0}};
            rk_q    <= {AES_BLOCK_W{1'b0}};
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

    // Handshake outputs decode only the state register.
    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
    assign out_text  = state_q;
    assign round_idx = round_q;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_iter_ctrl
// Self-checking bench for aes_iter_ctrl: known-answer table, intermediate
// register values, backpressure with input noise, reset mid-block,
// back-to-back throughput and random blocks against a byte-level AES model.
// -----------------------------------------------------------------------------
module tb_aes_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_text;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         busy;
    logic [3:0]   round_idx;

    int checks   = 0;
    int failures = 0;

    aes_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_text   (in_text),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
        bit           noise;
        bit           inter;
    } vec_t;

    vec_t vecs [3];

    // ---------------- reference model (byte-array AES-128) ----------------
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            end
            b = inv;
            sbox_tab[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_aes(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a [4];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) u[i] = sbox_tab[s[i]];
            for (int i = 0; i < 16; i++) s[i] = u[(i%4) + 4*(((i/4) + (i%4)) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[4*c + k];
                    for (int k = 0; k < 4; k++)
                        s[4*c + k] = gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03)
                                     ^ a[(k+2)%4] ^ a[(k+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one block, check latency/result, optionally hold the result under
    // backpressure with junk on the input side, then drain it.
    task automatic do_block(input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] exp, input string tag,
                            input int hold, input bit noise, input bit inter);
        int  n;
        int  edges;
        bit  stable;
        in_key   = key;
        in_text  = pt;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready"}, 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy_after_accept"}, {126'd0, busy, in_ready}, 128'd2);
        chk({tag, "_round1"}, 128'(round_idx), 128'd1);
        if (inter) chk({tag, "_state_after_load"}, dut.state_q, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        edges = 1;
        while (!out_valid && edges < 30) begin
            if (noise) begin
                in_valid = 1'($urandom);
                in_key   = rnd128();
                in_text  = rnd128();
            end
            @(posedge clk); #1;
            edges++;
            if (inter && edges == 2) chk({tag, "_rk_round1"}, dut.rk_q, 128'ha0fafe1788542cb123a339392a6c7605);
        end
        chk({tag, "_latency"}, 128'(edges), 128'd11);
        chk({tag, "_round_done"}, 128'(round_idx), 128'd10);
        chk({tag, "_ct"}, out_text, exp);
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                in_valid = 1'($urandom);
                in_key   = rnd128();
                in_text  = rnd128();
            end
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_text !== exp || in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 128'(stable), 128'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drain"}, {125'd0, in_ready, out_valid, busy}, 128'd4);
    endtask

    // Overall time limit so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        bit           no_pulse;
        int           acc_cyc [$];
        logic [127:0] outs [$];
        logic [127:0] k2;
        logic [127:0] p2;
        logic [127:0] rk;
        logic [127:0] rp;

        build_sbox();

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, 1'b0};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 20, 1'b1, 1'b1};
        vecs[2] = '{128'h00000000000000000000000000000000, 128'h00000000000000000000000000000000,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 3, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_key = 128'd0; in_text = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_handshake", {125'd0, in_ready, out_valid, busy}, 128'd4);
        chk("reset_text", out_text, 128'd0);
        chk("reset_round", 128'(round_idx), 128'd0);
        rst = 1'b0;

        // Known-answer table; the first block is offered right after reset.
        for (int v = 0; v < 3; v++) begin
            do_block(vecs[v].key, vecs[v].pt, vecs[v].ct, $sformatf("kat%0d", v),
                     vecs[v].hold, vecs[v].noise, vecs[v].inter);
        end

        // Reset in the middle of a block.
        in_key = vecs[0].key; in_text = vecs[0].pt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrun_reach_round5", 128'(round_idx), 128'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst_handshake", {125'd0, in_ready, out_valid, busy}, 128'd4);
        chk("midrun_rst_text", out_text, 128'd0);
        chk("midrun_rst_round", 128'(round_idx), 128'd0);
        no_pulse = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) no_pulse = 1'b0;
        end
        chk("midrun_no_pulse", 128'(no_pulse), 128'd1);
        do_block(vecs[0].key, vecs[0].pt, vecs[0].ct, "rerun_c1", 0, 1'b0, 1'b0);

        // Back-to-back blocks with in_valid and out_ready held high.
        k2 = rnd128(); p2 = rnd128();
        in_key = vecs[1].key; in_text = vecs[1].pt;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && outs.size() < 2; cyc++) begin
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (out_valid) outs.push_back(out_text);
            @(posedge clk); #1;
            if (acc_cyc.size() == 1) begin
                in_key = k2; in_text = p2;
            end
            if (acc_cyc.size() >= 2) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_accepts", 128'(acc_cyc.size()), 128'd2);
        chk("b2b_outputs", 128'(outs.size()), 128'd2);
        if (acc_cyc.size() == 2) chk("b2b_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
        if (outs.size() == 2) begin
            chk("b2b_ct0", outs[0], vecs[1].ct);
            chk("b2b_ct1", outs[1], model_aes(k2, p2));
        end
        @(posedge clk); #1;

        // Random blocks against the model.
        for (int r = 0; r < 6; r++) begin
            rk = rnd128(); rp = rnd128();
            do_block(rk, rp, model_aes(rk, rp), $sformatf("rnd%0d", r),
                     int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_iter_ctrl.md
AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

Interface
REQ-001 Parameters: none; the block is fixed to AES-128 encryption with 10 rounds.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  a plaintext/key pair is offered.
REQ-005 in_ready  output  1  the block can accept a pair; high only in IDLE.
REQ-006 in_key  input  128  cipher key; bit 127 is byte 0 (FIPS-197 order).
REQ-007 in_text  input  128  plaintext, same byte order.
REQ-008 out_valid  output  1  ciphertext is available; high only in DONE.
REQ-009 out_ready  input  1  the consumer takes the ciphertext.
REQ-010 out_text  output  128  ciphertext, same byte order.
REQ-011 busy  output  1  high in RUN or DONE.
REQ-012 round_idx  output  4  current round number, 0 in IDLE, 1..10 in RUN, 10 in DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on an edge with in_valid and in_ready: state_reg <= in_text ^ in_key, rk_reg <= in_key, round_idx <= 1.
REQ-015 RUN, rounds 1..9: at each edge, rk_reg <= expand(rk_reg, rcon[round_idx]).
REQ-016 RUN, rounds 1..9: at the same edge, state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ expand(rk_reg, rcon[round_idx]), and round_idx increments.
REQ-017 RUN with round_idx==10: MixColumns is omitted, the result is loaded into state_reg, and the FSM goes to DONE.
REQ-018 rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-019 expand() SHALL implement one AES-128 key-schedule step: w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
REQ-020 Latency: out_valid SHALL go high exactly 11 edges after the accepting edge: 1 load edge plus 10 round edges.
REQ-021 out_text SHALL equal state_reg at all times; it is meaningful only while out_valid is high.
REQ-022 DONE -> IDLE on an edge with out_ready high.
REQ-022a While out_ready is low in DONE, out_text and out_valid SHALL hold indefinitely.
REQ-023 in_ready SHALL be low in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT corrupt the computation.
REQ-024 After out_ready in DONE, in_ready SHALL be high in the following cycle; there is no overlap of consecutive blocks, so throughput is 1 block per 12 cycles minimum.
REQ-025 in_key and in_text are sampled only on the accepting edge; later changes to them SHALL have no effect.
REQ-026 Handshake outputs (in_ready, out_valid, busy) SHALL be driven from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-027 While rst is high at an edge, the block SHALL go to IDLE and clear state_reg, rk_reg and round_idx to 0.
REQ-028 Output values after reset SHALL be: in_ready=1, out_valid=0, busy=0, out_text=0, round_idx=0.
REQ-029 rst SHALL take priority over all handshakes.
REQ-030 A reset in RUN or DONE SHALL abort the block, and no out_valid pulse for it SHALL follow.
REQ-031 Acceptance SHALL be possible on the first edge after rst deasserts.

Structure
REQ-032 A shared package aes_pkg SHALL hold the FSM state typedef, the rcon table, and the S-box function or table.
REQ-033 The package SHALL also hold the AES_ROUNDS=10 and AES_BLOCK_W=128 constants.
REQ-034 One sub-module, aes_key_step, SHALL be purely combinational and implement expand(): input rk[127:0] and rcon[7:0], output rk_next[127:0].
REQ-035 The round transform SHALL use the team's shared SubBytes, ShiftRows and MixColumns combinational functions from aes_pkg.
REQ-036 The round transform SHALL be a single combinational stage with no extra pipeline registers.

Verification
REQ-037 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_text 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid exactly 11 cycles after acceptance.
REQ-038 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-039 App. B intermediate checks: state_reg after the load edge = 193de3bea0f4e22b9ac68d2ae9f84808, and rk_reg after round 1 = a0fafe1788542cb123a339392a6c7605.
REQ-040 Backpressure: hold out_ready low for 20 cycles in DONE -> out_text stable and out_valid high throughout; toggle in_valid with random data during RUN and DONE -> result unchanged.
REQ-041 Reset mid-RUN: assert rst when round_idx==5 -> next cycle in_ready=1, out_valid=0, out_text=0; then the C.1 vector re-run gives the correct ciphertext.
REQ-042 Back-to-back: in_valid held high with two vectors and out_ready tied high -> both ciphertexts correct and accepting edges 12 cycles apart.
